// File: rtl/res_hex_formatter_pkg.sv
// Shared constants, state encoding and nibble helper for the hex result formatter.
package uart_fmt_pkg;

    localparam int RES_W   = 32;
    localparam int NIB_CNT = 8;

    localparam logic [7:0] ASC_0    = 8'h30;
    localparam logic [7:0] ASC_X    = 8'h78;
    localparam logic [7:0] ASC_CR   = 8'h0D;
    localparam logic [7:0] ASC_LF   = 8'h0A;
    localparam logic [7:0] ASC_A_UP = 8'h41;
    localparam logic [7:0] ASC_A_LO = 8'h61;

    typedef enum logic [2:0] {
        IDLE,
        PFX0,
        PFXX,
        SKIP,
        DIGIT,
        CR,
        LF
    } fmt_state_t;

    // Pick nibble i (0 = least significant) out of a result word.
    function automatic logic [3:0] nib_at(input logic [RES_W-1:0] v, input logic [2:0] i);
        return v[{i, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/res_hex_formatter_if.sv
// Result-in / byte-out bus between the ALU stage, the formatter and the UART transmitter.
interface res_hex_formatter_if;
    import uart_fmt_pkg::*;

    logic             alu_done;
    logic [RES_W-1:0] calc_res;
    logic             tx_ready;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             busy;
    logic             frame_done;
    logic             overrun;

    // Producer of results / consumer of bytes (ALU + transmitter side).
    modport master (
        output alu_done, calc_res, tx_ready,
        input  tx_data, tx_valid, busy, frame_done, overrun
    );

    // The formatter itself.
    modport slave (
        input  alu_done, calc_res, tx_ready,
        output tx_data, tx_valid, busy, frame_done, overrun
    );

endinterface

// File: rtl/res_hex_formatter_nib2ascii.sv
// Combinational 4-bit nibble to ASCII hex character.
module nib2ascii
    import uart_fmt_pkg::*;
#(
    parameter bit UPPERCASE = 1'b1
) (
    input  logic [3:0] nib_i,
    output logic [7:0] asc_o
);

    // Digits map onto '0'..'9', letters onto the selected alphabet case.
    always_comb begin
        asc_o = ASC_0 + {4'h0, nib_i};
        if (nib_i > 4'd9)
            asc_o = (UPPERCASE ? ASC_A_UP : ASC_A_LO) + {4'h0, nib_i} - 8'd10;
    end

endmodule

// File: rtl/res_hex_formatter.sv
// Captures an ALU result and streams it as "0x<hex>[CR LF]" over a valid/ready byte bus.
module res_hex_formatter
    import uart_fmt_pkg::*;
#(
    parameter bit UPPERCASE      = 1'b1,
    parameter bit SUPPRESS_ZEROS = 1'b1,
    parameter bit EOL_EN         = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    res_hex_formatter_if.slave fmt
);

    fmt_state_t       state_q;
    logic [RES_W-1:0] res_q;
    logic [2:0]       idx_q;
    logic [7:0]       tx_data_q;
    logic             tx_valid_q;
    logic             busy_q;
    logic             frame_done_q;
    logic             overrun_q;

    logic       accept;
    logic       final_accept;
    logic [2:0] sel_idx;
    logic [3:0] sel_nib;
    logic [7:0] sel_asc;

    assign accept = tx_valid_q && fmt.tx_ready;

    // The accept that closes the frame: LF, or the last digit when no line ending.
    assign final_accept = accept &&
        ((state_q == LF) || (state_q == DIGIT && idx_q == 3'd0 && !EOL_EN));

    // While a digit is on the bus, the byte to load on accept is the next lower nibble;
    // elsewhere the current index is the nibble about to be examined or shown.
    assign sel_idx = (state_q == DIGIT) ? idx_q - 3'd1 : idx_q;
    assign sel_nib = nib_at(res_q, sel_idx);

    nib2ascii #(.UPPERCASE(UPPERCASE)) u_nib2ascii (
        .nib_i (sel_nib),
        .asc_o (sel_asc)
    );

    // Frame sequencer with registered byte, valid and status outputs.
    // The first zero nibble is consumed on the PFXX accept, so each suppressed
    // leading zero costs exactly one bubble cycle in SKIP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            res_q        <= '0;
            idx_q        <= '0;
            tx_data_q    <= 8'h00;
            tx_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            overrun_q    <= fmt.alu_done && (state_q != IDLE) && !final_accept;
            case (state_q)
                IDLE: if (fmt.alu_done) begin
                    res_q      <= fmt.calc_res;
                    idx_q      <= 3'(NIB_CNT - 1);
                    tx_data_q  <= ASC_0;
                    tx_valid_q <= 1'b1;
                    busy_q     <= 1'b1;
                    state_q    <= PFX0;
                end
                PFX0: if (accept) begin
                    tx_data_q <= ASC_X;
                    state_q   <= PFXX;
                end
                PFXX: if (accept) begin
                    if (SUPPRESS_ZEROS && sel_nib == 4'h0) begin
                        idx_q      <= idx_q - 3'd1;
                        tx_valid_q <= 1'b0;
                        state_q    <= SKIP;
                    end else begin
                        tx_data_q <= sel_asc;
                        state_q   <= DIGIT;
                    end
                end
                SKIP: begin
                    if (sel_nib == 4'h0 && idx_q != 3'd0) begin
                        idx_q <= idx_q - 3'd1;
                    end else begin
                        tx_data_q  <= sel_asc;
                        tx_valid_q <= 1'b1;
                        state_q    <= DIGIT;
                    end
                end
                DIGIT: if (accept) begin
                    if (idx_q != 3'd0) begin
                        idx_q     <= idx_q - 3'd1;
                        tx_data_q <= sel_asc;
                    end else if (EOL_EN) begin
                        tx_data_q <= ASC_CR;
                        state_q   <= CR;
                    end
                end
                CR: if (accept) begin
                    tx_data_q <= ASC_LF;
                    state_q   <= LF;
                end
                LF: ;
                default: state_q <= IDLE;
            endcase

            // Frame end overrides the case above; a coincident alu_done chains the next frame.
            if (final_accept) begin
                frame_done_q <= 1'b1;
                if (fmt.alu_done) begin
                    res_q      <= fmt.calc_res;
                    idx_q      <= 3'(NIB_CNT - 1);
                    tx_data_q  <= ASC_0;
                    tx_valid_q <= 1'b1;
                    busy_q     <= 1'b1;
                    state_q    <= PFX0;
                end else begin
                    tx_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
            end
        end
    end

    assign fmt.tx_data    = tx_data_q;
    assign fmt.tx_valid   = tx_valid_q;
    assign fmt.busy       = busy_q;
    assign fmt.frame_done = frame_done_q;
    assign fmt.overrun    = overrun_q;

endmodule

// File: tb/tb_res_hex_formatter.sv
// Bench for res_hex_formatter: four parameter variants, random and directed frames,
// checked against a string-building reference model.
module tb_res_hex_formatter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  ad;
    logic [31:0] calc_res;
    logic        tx_ready;

    logic [3:0]  valid_w, busy_w, fd_w, ov_w;
    logic [7:0]  data_w [4];

    always #5 clk = ~clk;

    // Variant g: 0 default, 1 lowercase, 2 no zero suppression, 3 no line ending.
    for (genvar g = 0; g < 4; g++) begin : g_dut
        res_hex_formatter_if ifc ();
        assign ifc.alu_done = ad[g];
        assign ifc.calc_res = calc_res;
        assign ifc.tx_ready = tx_ready;
        res_hex_formatter #(
            .UPPERCASE      (g != 1),
            .SUPPRESS_ZEROS (g != 2),
            .EOL_EN         (g != 3)
        ) dut (
            .clk (clk),
            .rst (rst),
            .fmt (ifc)
        );
        assign valid_w[g] = ifc.tx_valid;
        assign data_w[g]  = ifc.tx_data;
        assign busy_w[g]  = ifc.busy;
        assign fd_w[g]    = ifc.frame_done;
        assign ov_w[g]    = ifc.overrun;
    end

    int n_chk = 0, n_err = 0;
    int sel = 0, rmode = 0, cyc = 0;
    logic [7:0] got_q[$], exp_q[$];
    int busy_cyc, low_cyc, fd_cnt, ov_cnt, stab_err, exp_skip;
    logic       prev_hold;
    logic [7:0] prev_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit p_up(input int k);  return k != 1; endfunction
    function automatic bit p_sup(input int k); return k != 2; endfunction
    function automatic bit p_eol(input int k); return k != 3; endfunction

    // Reference: the text a human would type for this value and variant.
    task automatic build_exp(input int k, input logic [31:0] v);
        int first;
        int d;
        exp_q.push_back(8'h30);
        exp_q.push_back(8'h78);
        first = 7;
        if (p_sup(k))
            while (first > 0 && ((v >> (4 * first)) & 32'hF) == 0) first--;
        exp_skip += 7 - first;
        for (int i = first; i >= 0; i--) begin
            d = int'((v >> (4 * i)) & 32'hF);
            if (d < 10) exp_q.push_back(8'(48 + d));
            else        exp_q.push_back(8'((p_up(k) ? 65 : 97) + d - 10));
        end
        if (p_eol(k)) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endtask

    // Ready pattern: 0 always, 1 every third cycle, 2 random.
    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            case (rmode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = (cyc % 3 == 0);
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Observe the selected variant away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (busy_w[sel]) busy_cyc++;
            if (busy_w[sel] && !valid_w[sel]) low_cyc++;
            if (valid_w[sel] && tx_ready) got_q.push_back(data_w[sel]);
            if (prev_hold && (!valid_w[sel] || data_w[sel] !== prev_data)) stab_err++;
            prev_hold = valid_w[sel] && !tx_ready;
            prev_data = data_w[sel];
            if (fd_w[sel]) fd_cnt++;
            if (ov_w[sel]) ov_cnt++;
        end
    end

    task automatic clear(input int k);
        sel = k;
        got_q.delete();
        exp_q.delete();
        busy_cyc = 0; low_cyc = 0; fd_cnt = 0; ov_cnt = 0;
        stab_err = 0; exp_skip = 0; prev_hold = 1'b0;
    endtask

    task automatic start_frame(input int k, input logic [31:0] v);
        @(posedge clk); #1;
        ad[k]    = 1'b1;
        calc_res = v;
        @(posedge clk); #1;
        ad = '0;
    endtask

    task automatic wait_done(input int n);
        int c = 0;
        while (fd_cnt < n && c < 600) begin
            @(posedge clk);
            c++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("frame_timeout", 32'(fd_cnt >= n), 32'd1);
    endtask

    task automatic check_frame(input int n_fd, input int n_ov, input bit timed);
        int n;
        chk("len", got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk($sformatf("byte%0d", i), got_q[i], exp_q[i]);
        chk("skip_cycles", low_cyc, exp_skip);
        chk("frame_done_cnt", fd_cnt, n_fd);
        chk("overrun_cnt", ov_cnt, n_ov);
        chk("stable", stab_err, 0);
        if (timed) chk("frame_cycles", busy_cyc, exp_q.size() + exp_skip);
    endtask

    task automatic run_frame(input int k, input logic [31:0] v, input int rm);
        rmode = rm;
        clear(k);
        build_exp(k, v);
        start_frame(k, v);
        @(negedge clk);
        chk("latency", {valid_w[k], data_w[k]}, {23'd0, 1'b1, 8'h30});
        wait_done(1);
        check_frame(1, 0, rm == 0);
    endtask

    initial begin
        int c;
        logic [31:0] v;
        rst = 1'b1; ad = '0; calc_res = '0;
        #12;
        for (int k = 0; k < 4; k++)
            chk($sformatf("reset_state%0d", k),
                {valid_w[k], data_w[k], busy_w[k], fd_w[k], ov_w[k]}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed frames from the test plan.
        run_frame(0, 32'h0000_00A5, 0);
        run_frame(0, 32'h0000_0000, 0);
        run_frame(2, 32'h0000_0000, 0);
        run_frame(1, 32'hDEAD_BEEF, 1);
        run_frame(2, 32'hFFFF_FFFF, 0);
        run_frame(3, 32'h0000_1234, 2);

        // Overrun mid-frame, then a chained frame on the LF accept.
        rmode = 0;
        clear(0);
        build_exp(0, 32'h1234_5678);
        build_exp(0, 32'h0000_0002);
        start_frame(0, 32'h1234_5678);
        repeat (3) @(posedge clk);
        #1;
        ad[0] = 1'b1; calc_res = 32'h1;
        @(posedge clk); #1;
        ad = '0;
        @(negedge clk);
        chk("overrun_pulse", ov_w[0], 1'b1);
        c = 0;
        while (!(valid_w[0] && data_w[0] == 8'h0A) && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk("lf_seen", 32'(c < 100), 32'd1);
        ad[0] = 1'b1; calc_res = 32'h2;
        @(posedge clk); #1;
        ad = '0;
        @(negedge clk);
        chk("chain_no_bubble", {busy_w[0], valid_w[0], data_w[0]}, {22'd0, 2'b11, 8'h30});
        wait_done(2);
        check_frame(2, 1, 1'b1);

        // Reset while the first digit 'E' is on the bus.
        rmode = 2;
        clear(0);
        start_frame(0, 32'h0000_00E5);
        c = 0;
        while (!(valid_w[0] && data_w[0] == 8'h45) && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("digit_e_seen", 32'(c < 200), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_reset", {valid_w[0], busy_w[0], data_w[0]}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        run_frame(0, 32'h0000_0007, 0);

        // Random values with random leading-zero depth on random variants.
        for (int i = 0; i < 16; i++) begin
            v = $urandom >> ($urandom_range(0, 8) * 4);
            run_frame(int'($urandom_range(0, 3)), v, int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/res_hex_formatter.md
# res_hex_formatter

Downstream of the ALU stage in the UART hex calculator. Captures the 32-bit `calc_res` on each `alu_done` pulse, renders it as an ASCII string `0x<hex digits><CR><LF>`, and streams the bytes one at a time to the UART transmitter over a valid/ready handshake. It turns the calculator's result into terminal-visible output and shares the transmitter's byte-input path with the echo path.

## Interface
- `UPPERCASE`, 1: hex letters emitted as `A`–`F` (0x41–0x46); 0 gives `a`–`f` (0x61–0x66).
- `SUPPRESS_ZEROS`, 1: leading zero nibbles are omitted; 0 always emits 8 digits.
- `EOL_EN`, 1: append CR (0x0D), LF (0x0A); 0 ends the frame after the last digit.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `alu_done`  in  1  one-cycle pulse; `calc_res` is valid in the same cycle.
- `calc_res`  in  32  result to print.
- `tx_ready`  in  1  transmitter can accept a byte this cycle.
- `tx_data`  out  8  ASCII byte offered to the transmitter.
- `tx_valid`  out  1  `tx_data` is valid.
- `busy`  out  1  a frame is in progress (state ≠ IDLE).
- `frame_done`  out  1  one-cycle pulse when the final byte is accepted.
- `overrun`  out  1  one-cycle pulse when an `alu_done` is dropped.

## Operation
- A byte transfers on the rising edge where `tx_valid && tx_ready`.
- While `tx_valid` is high, `tx_data` stays stable until the byte is accepted.
- `tx_valid` never drops without a transfer, except on reset.
- State machine: IDLE, PFX0, PFXX, SKIP, DIGIT, CR, LF.
- **IDLE:** on `alu_done`, latch `calc_res` into `res_q` and clear the nibble index (`idx` = 7, MSB nibble first). Go to PFX0.
- **PFX0:** offer `0` (0x30). On accept, go to PFXX.
- **PFXX:** offer `x` (0x78). On accept, go to SKIP if `SUPPRESS_ZEROS`, else DIGIT.
- **SKIP:** `tx_valid` = 0; one nibble is examined per cycle.
  - If `res_q[idx]` == 0 and `idx` > 0: decrement `idx` and stay in SKIP.
  - Otherwise go to DIGIT.
  - Nibble 0 is never skipped, so a value of 0 prints `0x0`.
- **DIGIT:** offer the ASCII of `res_q[idx]`.
  - On accept with `idx` > 0: decrement `idx` and stay in DIGIT.
  - On accept with `idx` == 0: go to CR if `EOL_EN`, else finish.
- **CR:** offer 0x0D. On accept, go to LF.
- **LF:** offer 0x0A. On accept, finish.
- **Finish:**
  - Pulse `frame_done`.
  - Go to IDLE; if `alu_done` is high in the same cycle as the final accept, instead latch the new `calc_res` and go directly to PFX0 (back-to-back, no bubble).
- **Overrun:** `alu_done` in any non-IDLE state other than the final-accept cycle is ignored, `res_q` is unchanged, and `overrun` pulses the next cycle.
- **Nibble to ASCII:** 0–9 map to 0x30–0x39; 10–15 map to 0x41+n-10 (`UPPERCASE` = 1) or 0x61+n-10 (`UPPERCASE` = 0).

## Timing
- Reset values: `tx_valid` = 0, `tx_data` = 0x00, `busy` = 0, `frame_done` = 0, `overrun` = 0, state = IDLE, `res_q` = 0. All outputs are registered.
- Latency: `alu_done` in cycle N gives `tx_valid` = 1 with 0x30 in cycle N+1.
- SKIP costs k cycles for k suppressed leading zero nibbles, with `tx_valid` low throughout.
- Minimum frame time with `tx_ready` tied high: 12 cycles for a full 8-digit frame with EOL, plus skip cycles when suppressing.
- Reset asserted mid-frame drops `tx_valid` asynchronously. The partial frame is abandoned and is not resumed after reset release.
- `tx_ready` may toggle arbitrarily; the block holds its byte while `tx_ready` is low.

## Structure
- Package `uart_fmt_pkg`:
  - ASCII constants `ASC_0`, `ASC_X`, `ASC_CR`, `ASC_LF`, `ASC_A_UP`, `ASC_A_LO`.
  - State enum `fmt_state_t`.
  - `RES_W` = 32, `NIB_CNT` = 8.
- One sub-module, `nib2ascii`: combinational 4-bit to 8-bit conversion, parameterised by `UPPERCASE`.
- Top-level integration: a 2:1 byte mux in front of the transmitter (echo vs. formatter). That mux is not part of this block.

## Test plan
- `calc_res` = 0x0000_00A5, `tx_ready` = 1, default params -> bytes 30 78 41 35 0D 0A. `tx_valid` is low for the 6 skip cycles. `frame_done` pulses once.
- `calc_res` = 0 -> 30 78 30 0D 0A. With `SUPPRESS_ZEROS` = 0 -> 30 78 followed by eight 30s, then 0D 0A.
- `calc_res` = 0xDEAD_BEEF, `tx_ready` pulsed every 3rd cycle, `UPPERCASE` = 0 -> 30 78 64 65 61 64 62 65 65 66 0D 0A. `tx_data` is stable whenever valid is high and ready is low.
- Second `alu_done` (0x1) mid-frame -> `overrun` pulse, first frame unchanged. A third `alu_done` (0x2) coincident with LF accept -> frame 30 78 32 0D 0A starts the next cycle.
- `rst` asserted while DIGIT is offering 0x45 -> `tx_valid` is 0 immediately. After release, an `alu_done` with 0x7 yields 30 78 37 0D 0A.
